// File: rtl/mult_pkg.sv
`default_nettype none
// ============================================================================
// Module : mult_pkg
// Shared state encoding and parameter defaults for the multiplier scheduler.
// Rev    : 1.0
// ============================================================================
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        RESP = 2'd3
    } sched_state_t;

    localparam int c_DEF_N = 4;
    localparam int c_DEF_R = 3;

    // Run-cycle budget before the engine is declared faulty.
    function automatic int default_timeout(input int n);
        return 2 * n + 4;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module : rr_arbiter
// Combinational round-robin pick: lowest requesting index at or after i_ptr.
// Rev    : 1.0
// ============================================================================
module rr_arbiter #(
    parameter int R  = 3,
    parameter int PW = (R > 1) ? $clog2(R) : 1
) (
    input  logic [R-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    output logic [R-1:0]  o_grant_onehot,
    output logic [PW-1:0] o_grant_idx,
    output logic          o_any
);

    int            w_idx;
    logic [PW-1:0] w_sel;

    always_comb begin
        o_grant_onehot = '0;
        o_grant_idx    = '0;
        o_any          = 1'b0;
        w_idx          = 0;
        w_sel          = '0;
        // Walk from the farthest offset inwards so the nearest request wins.
        for (int k = R - 1; k >= 0; k--) begin
            w_idx = (int'(i_ptr) + k) % R;
            w_sel = PW'(w_idx);
            if (i_req[w_sel]) begin
                o_grant_onehot = R'(1) << w_sel;
                o_grant_idx    = w_sel;
                o_any          = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mult_sched.sv
`default_nettype none
// ============================================================================
// Module : mult_sched
// Shares one sequential signed multiplier engine among R requesters.
// Rev    : 1.0
// ============================================================================
module mult_sched
    import mult_pkg::*;
#(
    parameter int N       = c_DEF_N,
    parameter int R       = c_DEF_R,
    parameter int TIMEOUT = default_timeout(N)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [R-1:0]         req_valid,
    input  logic [R*N-1:0]       req_q,
    input  logic [R*N-1:0]       req_m,
    output logic [R-1:0]         req_ready,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [$clog2(R)-1:0] rsp_id,
    output logic [2*N-1:0]       rsp_p,
    output logic                 rsp_err,
    output logic                 busy,
    output logic                 eng_run,
    output logic [N-1:0]         eng_q,
    output logic [N-1:0]         eng_m,
    input  logic                 eng_done,
    input  logic [2*N-1:0]       eng_p
);

    localparam int c_IW = $clog2(R);
    localparam int c_CW = $clog2(TIMEOUT + 1);

    sched_state_t    r_state;
    logic [c_IW-1:0] r_ptr;
    logic [c_IW-1:0] r_id;
    logic [N-1:0]    r_q;
    logic [N-1:0]    r_m;
    logic [c_CW-1:0] r_cnt;
    logic [2*N-1:0]  r_rsp_p;
    logic            r_rsp_err;
    logic            r_rsp_valid;
    logic            r_busy;
    logic            r_eng_run;

    logic [R-1:0]    w_grant;
    logic [c_IW-1:0] w_gidx;
    logic            w_any;
    logic [N-1:0]    w_sel_q;
    logic [N-1:0]    w_sel_m;
    logic [c_IW-1:0] w_ptr_next;

    rr_arbiter #(
        .R  (R),
        .PW (c_IW)
    ) u_arb (
        .i_req          (req_valid),
        .i_ptr          (r_ptr),
        .o_grant_onehot (w_grant),
        .o_grant_idx    (w_gidx),
        .o_any          (w_any)
    );

    assign w_sel_q    = req_q[int'(w_gidx) * N +: N];
    assign w_sel_m    = req_m[int'(w_gidx) * N +: N];
    assign w_ptr_next = (w_gidx == c_IW'(R - 1)) ? '0 : w_gidx + 1'b1;

    // Accept pulse is combinational so the winner sees it in its grant cycle.
    assign req_ready = (r_state == IDLE && !reset) ? w_grant : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_id        <= '0;
            r_q         <= '0;
            r_m         <= '0;
            r_cnt       <= '0;
            r_rsp_p     <= '0;
            r_rsp_err   <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_eng_run   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_q     <= w_sel_q;
                        r_m     <= w_sel_m;
                        r_id    <= w_gidx;
                        r_ptr   <= w_ptr_next;
                        r_busy  <= 1'b1;
                        r_state <= LOAD;
                    end
                end
                LOAD: begin
                    r_cnt     <= '0;
                    r_eng_run <= 1'b1;
                    r_state   <= RUN;
                end
                RUN: begin
                    // Done takes priority over a timeout landing in the same cycle.
                    if (eng_done) begin
                        r_rsp_p     <= eng_p;
                        r_rsp_err   <= 1'b0;
                        r_eng_run   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= RESP;
                    end else if (r_cnt == c_CW'(TIMEOUT - 1)) begin
                        r_rsp_p     <= '0;
                        r_rsp_err   <= 1'b1;
                        r_eng_run   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= RESP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_eng_run   <= 1'b0;
                    r_rsp_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_id;
    assign rsp_p     = r_rsp_p;
    assign rsp_err   = r_rsp_err;
    assign busy      = r_busy;
    assign eng_run   = r_eng_run;
    assign eng_q     = r_q;
    assign eng_m     = r_m;

endmodule
`default_nettype wire

// File: tb/tb_mult_sched.sv
`default_nettype none
// ============================================================================
// Module : tb_mult_sched
// Self-checking bench for mult_sched with a stand-in N=4 engine.
// Rev    : 1.0
// ============================================================================
module tb_mult_sched;

    localparam int N  = 4;
    localparam int R  = 3;
    localparam int TO = 2 * N + 4;
    localparam int IW = $clog2(R);

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [R-1:0]   req_valid = '0;
    logic [R*N-1:0] req_q = '0;
    logic [R*N-1:0] req_m = '0;
    logic [R-1:0]   req_ready;
    logic           rsp_valid;
    logic           rsp_ready = 1'b1;
    logic [IW-1:0]  rsp_id;
    logic [2*N-1:0] rsp_p;
    logic           rsp_err;
    logic           busy;
    logic           eng_run;
    logic [N-1:0]   eng_q;
    logic [N-1:0]   eng_m;
    logic           eng_done;
    logic [2*N-1:0] eng_p;

    int n_total = 0;
    int n_pass  = 0;
    int cyc     = 0;

    always #5 clk = ~clk;

    mult_sched #(.N(N), .R(R), .TIMEOUT(TO)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_q     (req_q),
        .req_m     (req_m),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_p     (rsp_p),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .eng_run   (eng_run),
        .eng_q     (eng_q),
        .eng_m     (eng_m),
        .eng_done  (eng_done),
        .eng_p     (eng_p)
    );

    function automatic logic [7:0] smul(input logic [3:0] a, input logic [3:0] b);
        int ia;
        int ib;
        ia = $signed(a);
        ib = $signed(b);
        return 8'(ia * ib);
    endfunction

    function automatic int pick(input logic [R-1:0] v, input int p);
        for (int k = 0; k < R; k++) begin
            if (v[(p + k) % R]) return (p + k) % R;
        end
        return -1;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s (cycle %0d): got %0h, want %0h", nm, cyc, act, exp);
    endtask

    // Stand-in engine: loads while run=0, raises sticky done in its Nth run cycle.
    bit           stuck  = 1'b0;
    bit           glitch = 1'b0;
    logic [3:0]   e_q, e_m;
    int           e_cnt = 0;
    logic [7:0]   junk = 8'h00;

    always @(posedge clk) begin
        junk <= 8'($urandom);
        if (!eng_run) begin
            e_q   <= eng_q;
            e_m   <= eng_m;
            e_cnt <= 0;
        end else if (e_cnt < 63) begin
            e_cnt <= e_cnt + 1;
        end
    end
    assign eng_done = eng_run ? (!stuck && e_cnt >= N - 1) : glitch;
    assign eng_p    = (eng_run && eng_done) ? smul(e_q, e_m) : junk;

    // Transaction-level model plus a log of what the DUT actually did.
    bit         m_busy = 1'b0;
    int         m_ptr = 0, m_acc = 0, m_lat = 0, m_id = 0;
    logic [3:0] m_q, m_m;
    logic [7:0] m_p;
    bit         m_err;
    bit         rsp_seen = 1'b0;
    int         acc_cyc[$], acc_idx[$], log_cyc[$], log_id[$], log_err[$];
    logic [7:0] log_p[$];

    always @(negedge clk) begin : p_cmp
        int           g;
        int           d;
        logic [R-1:0] exp_rdy;
        cyc++;
        if (reset) begin
            m_busy   = 1'b0;
            m_ptr    = 0;
            rsp_seen = 1'b0;
            chk("rst_req_ready", 32'(req_ready), 0);
            chk("rst_rsp_valid", 32'(rsp_valid), 0);
            chk("rst_busy", 32'(busy), 0);
            chk("rst_eng_run", 32'(eng_run), 0);
        end else begin
            if (req_ready != '0) begin
                acc_cyc.push_back(cyc);
                for (int i = 0; i < R; i++) if (req_ready[i]) acc_idx.push_back(i);
            end
            if (rsp_valid && !rsp_seen) begin
                log_cyc.push_back(cyc);
                log_id.push_back(int'(rsp_id));
                log_p.push_back(rsp_p);
                log_err.push_back(int'(rsp_err));
                rsp_seen = 1'b1;
            end
            if (rsp_valid && rsp_ready) rsp_seen = 1'b0;

            if (!m_busy) begin
                g       = pick(req_valid, m_ptr);
                exp_rdy = (g >= 0) ? (R'(1) << g) : '0;
                chk("req_ready", 32'(req_ready), 32'(exp_rdy));
                chk("busy_idle", 32'(busy), 0);
                chk("rsp_valid_idle", 32'(rsp_valid), 0);
                chk("eng_run_idle", 32'(eng_run), 0);
                if (g >= 0) begin
                    m_busy = 1'b1;
                    m_acc  = cyc;
                    m_id   = g;
                    m_q    = req_q[g*N +: N];
                    m_m    = req_m[g*N +: N];
                    m_err  = stuck;
                    m_p    = stuck ? 8'h00 : smul(m_q, m_m);
                    m_lat  = stuck ? TO + 2 : N + 2;
                    m_ptr  = (g + 1) % R;
                end
            end else begin
                d = cyc - m_acc;
                chk("req_ready_busy", 32'(req_ready), 0);
                chk("busy", 32'(busy), 1);
                chk("eng_run", 32'(eng_run), 32'(d >= 2 && d < m_lat));
                chk("rsp_valid", 32'(rsp_valid), 32'(d >= m_lat));
                chk("eng_q", 32'(eng_q), 32'(m_q));
                chk("eng_m", 32'(eng_m), 32'(m_m));
                if (d >= m_lat) begin
                    chk("rsp_id", 32'(rsp_id), m_id);
                    chk("rsp_p", 32'(rsp_p), 32'(m_p));
                    chk("rsp_err", 32'(rsp_err), 32'(m_err));
                    if (rsp_ready) m_busy = 1'b0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [3:0] q, input logic [3:0] m);
        req_q[i*N +: N] = q;
        req_m[i*N +: N] = m;
    endtask

    task automatic wait_rsp(input int n, input int bound);
        int k;
        k = 0;
        while (log_id.size() < n && k < bound) begin
            tick();
            k++;
        end
        chk("rsp_wait", 32'(log_id.size() >= n), 1);
    endtask

    initial begin : p_wdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : p_stim
        int lb, ab, k;
        repeat (3) tick();
        chk("reset_rsp_p", 32'(rsp_p), 0);
        chk("reset_eng_q", 32'(eng_q), 0);
        chk("reset_rsp_id", 32'(rsp_id), 0);
        reset = 1'b0;
        tick();

        // 1: single request 3 * -2
        lb = log_id.size(); ab = acc_idx.size();
        set_req(0, 4'd3, 4'hE);
        req_valid = 3'b001;
        tick();
        req_valid = '0;
        wait_rsp(lb + 1, 30);
        if (log_id.size() > lb && acc_idx.size() > ab) begin
            chk("t1_grant", acc_idx[ab], 0);
            chk("t1_lat", log_cyc[lb] - acc_cyc[ab], 6);
            chk("t1_p", 32'(log_p[lb]), 32'h0FA);
            chk("t1_id", log_id[lb], 0);
            chk("t1_err", log_err[lb], 0);
        end
        tick();

        // 2: all requesters valid from a fresh pointer, done glitching outside RUN
        reset = 1'b1;
        tick();
        reset  = 1'b0;
        glitch = 1'b1;
        lb = log_id.size(); ab = acc_idx.size();
        set_req(0, 4'd1, 4'd1);
        set_req(1, 4'h8, 4'h8);
        set_req(2, 4'd7, 4'hF);
        req_valid = 3'b111;
        k = 0;
        while (acc_idx.size() < ab + 3 && k < 60) begin
            tick();
            k++;
        end
        req_valid = '0;
        wait_rsp(lb + 3, 30);
        glitch = 1'b0;
        if (log_id.size() >= lb + 3) begin
            chk("t2_id0", log_id[lb], 0);
            chk("t2_id1", log_id[lb+1], 1);
            chk("t2_id2", log_id[lb+2], 2);
            chk("t2_p0", 32'(log_p[lb]), 32'h01);
            chk("t2_p1", 32'(log_p[lb+1]), 32'h40);
            chk("t2_p2", 32'(log_p[lb+2]), 32'hF9);
            chk("t2_gap1", log_cyc[lb+1] - log_cyc[lb], 7);
            chk("t2_gap2", log_cyc[lb+2] - log_cyc[lb+1], 7);
        end
        tick();

        // 3: consumer stalls in RESP while everyone requests
        lb = log_id.size();
        rsp_ready = 1'b0;
        set_req(0, 4'd2, 4'd3);
        req_valid = 3'b001;
        tick();
        req_valid = '0;
        wait_rsp(lb + 1, 30);
        req_valid = 3'b111;
        repeat (10) tick();
        chk("t3_busy", 32'(busy), 1);
        chk("t3_valid", 32'(rsp_valid), 1);
        chk("t3_ready", 32'(req_ready), 0);
        chk("t3_p", 32'(rsp_p), 32'h06);
        chk("t3_id", 32'(rsp_id), 0);
        req_valid = '0;
        rsp_ready = 1'b1;
        tick();
        tick();

        // 4: engine never finishes, then a normal op
        lb = log_id.size(); ab = acc_idx.size();
        stuck = 1'b1;
        tick();
        set_req(1, 4'd5, 4'd5);
        req_valid = 3'b010;
        tick();
        req_valid = '0;
        wait_rsp(lb + 1, 40);
        if (log_id.size() > lb && acc_idx.size() > ab) begin
            chk("t4_err", log_err[lb], 1);
            chk("t4_p", 32'(log_p[lb]), 0);
            chk("t4_id", log_id[lb], 1);
            chk("t4_lat", log_cyc[lb] - acc_cyc[ab], TO + 2);
        end
        tick();
        stuck = 1'b0;
        set_req(2, 4'hD, 4'd2);
        req_valid = 3'b100;
        tick();
        req_valid = '0;
        wait_rsp(lb + 2, 30);
        if (log_id.size() >= lb + 2) begin
            chk("t4_next_err", log_err[lb+1], 0);
            chk("t4_next_p", 32'(log_p[lb+1]), 32'hFA);
            chk("t4_next_id", log_id[lb+1], 2);
        end
        tick();

        // 5: reset lands mid-RUN
        set_req(1, 4'd2, 4'd3);
        req_valid = 3'b010;
        tick();
        req_valid = '0;
        k = 0;
        while (!eng_run && k < 20) begin
            tick();
            k++;
        end
        chk("t5_in_run", 32'(eng_run), 1);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("t5_eng_run", 32'(eng_run), 0);
        chk("t5_busy", 32'(busy), 0);
        chk("t5_valid", 32'(rsp_valid), 0);
        @(posedge clk);
        #1 reset = 1'b0;
        lb = log_id.size();
        set_req(2, 4'hF, 4'd5);
        req_valid = 3'b100;
        tick();
        req_valid = '0;
        wait_rsp(lb + 1, 30);
        if (log_id.size() > lb) begin
            chk("t5_id", log_id[lb], 2);
            chk("t5_p", 32'(log_p[lb]), 32'hFB);
        end
        tick();

        // 6: one requester hammering
        lb = log_id.size();
        set_req(1, 4'hF, 4'hF);
        req_valid = 3'b010;
        wait_rsp(lb + 4, 60);
        req_valid = '0;
        for (int i = 0; i < 4; i++) begin
            if (log_id.size() > lb + i) begin
                chk("t6_id", log_id[lb+i], 1);
                chk("t6_p", 32'(log_p[lb+i]), 32'h01);
            end
        end
        tick();

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            req_valid = R'($urandom_range(0, 7));
            req_q     = (R*N)'($urandom);
            req_m     = (R*N)'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            glitch    = 1'($urandom_range(0, 1));
            tick();
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        glitch    = 1'b0;
        k = 0;
        while (busy && k < 40) begin
            tick();
            k++;
        end
        chk("drain_idle", 32'(busy), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
